// File: rtl/reg_dump_reader.sv
// Sequential dump reader: walks R0..R(NUM_REGS-1) through a combinational read
// port and streams {index, data} words on a valid/ready interface.
module reg_dump_reader #(
  parameter int NUM_REGS = 8,
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_abort,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_out_data,
  output logic [ADDR_W-1:0] o_out_index,
  output logic              o_busy,
  output logic              o_done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_SEND,
    S_DONE
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_idx, w_idx_nxt;
  logic [ADDR_W-1:0] r_rd_addr, w_rd_addr_nxt;
  logic [DATA_W-1:0] r_out_data, w_out_data_nxt;
  logic [ADDR_W-1:0] r_out_index, w_out_index_nxt;
  logic              r_out_valid, w_out_valid_nxt;
  logic              r_busy, r_done;
  logic              w_busy_nxt, w_done_nxt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_rd_addr   <= '0;
      r_out_data  <= '0;
      r_out_index <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_rd_addr   <= w_rd_addr_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_index <= w_out_index_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_rd_addr_nxt   = r_rd_addr;
    w_out_data_nxt  = r_out_data;
    w_out_index_nxt = r_out_index;
    w_out_valid_nxt = r_out_valid;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_idx_nxt     = '0;
          w_rd_addr_nxt = '0;
          w_state_nxt   = S_SETUP;
        end
      end
      S_SETUP: begin
        if (i_abort) begin
          w_state_nxt     = S_IDLE;
          w_out_valid_nxt = 1'b0;
          w_rd_addr_nxt   = '0;
        end else begin
          w_out_data_nxt  = i_rd_data;
          w_out_index_nxt = r_idx;
          w_out_valid_nxt = 1'b1;
          w_state_nxt     = S_SEND;
        end
      end
      S_SEND: begin
        // abort wins over a same-cycle handshake; that word is dropped
        if (i_abort) begin
          w_state_nxt     = S_IDLE;
          w_out_valid_nxt = 1'b0;
          w_rd_addr_nxt   = '0;
        end else if (i_out_ready) begin
          w_out_valid_nxt = 1'b0;
          if (r_idx == LAST_IDX) begin
            w_state_nxt = S_DONE;
          end else begin
            w_idx_nxt     = r_idx + ADDR_W'(1);
            w_rd_addr_nxt = r_idx + ADDR_W'(1);
            w_state_nxt   = S_SETUP;
          end
        end
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_rd_addr_nxt = '0;
      end
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_done_nxt = (w_state_nxt == S_DONE);
  end

  assign o_rd_addr   = r_rd_addr;
  assign o_out_data  = r_out_data;
  assign o_out_index = r_out_index;
  assign o_out_valid = r_out_valid;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

// File: doc/reg_dump_reader.md
Name: reg_dump_reader

Overview:
- Sequential reader for the 8x16 general-purpose register file.
- On a start pulse it walks R0..R(NUM_REGS-1) through a spare combinational read port: drives the read address, captures the returned word, and presents it as {index, data} on a valid/ready stream.
- The stream consumer is the hex-display/debug path.
- It gives the register file's write side a matching reader, so the lab bench can dump all registers after a program halts.

Parameters:
- NUM_REGS, 8, number of registers dumped, starting at R0 (1..8).
- DATA_W, 16, register width.
- ADDR_W, 3, register index width.

Ports:
- Clk  input  1  system clock, rising-edge.
- Reset  input  1  asynchronous, active-high reset.
- start  input  1  begin a dump; sampled only in IDLE.
- abort  input  1  cancel a dump in progress; return to IDLE.
- rd_addr  output  ADDR_W  register index to the register file's read port (registered).
- rd_data  input  DATA_W  combinational read data for rd_addr.
- out_valid  output  1  stream data valid.
- out_ready  input  1  consumer accepts the current word.
- out_data  output  DATA_W  captured register value.
- out_index  output  ADDR_W  index of the register in out_data.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset (async, active-high): state=IDLE; idx, rd_addr, out_data, out_index = 0; out_valid, busy, done = 0. Applies at any point mid-dump; no done pulse is produced.
- All outputs are registered; none depends combinationally on inputs.
- States: IDLE, SETUP, SEND, DONE.
- IDLE:
  - start=1 at an edge -> idx<=0, rd_addr<=0, state<=SETUP.
  - start=0 -> stay.
  - abort is ignored in IDLE.
- SETUP: rd_addr holds idx for one full cycle so rd_data settles. At the next edge: out_data<=rd_data, out_index<=idx, out_valid<=1, state<=SEND.
- SEND:
  - out_valid=1; out_data and out_index are held stable until the handshake.
  - Handshake = out_valid & out_ready at a rising edge. On handshake, out_valid<=0, then:
    - idx==NUM_REGS-1 -> state<=DONE;
    - otherwise idx<=idx+1, rd_addr<=idx+1, state<=SETUP.
  - out_ready=0 -> stay in SEND indefinitely.
- DONE: done=1 for exactly one cycle, then state<=IDLE, rd_addr<=0. out_data and out_index keep the last word.
- abort=1 in SETUP, SEND or DONE -> next edge: state<=IDLE, out_valid<=0, done stays 0, rd_addr<=0. abort has priority over a simultaneous handshake; that word is considered not transferred.
- start while busy is ignored; no restart or queueing. start held high through DONE->IDLE begins a new dump at the first IDLE edge.
- Timing with out_ready tied high:
  - start is sampled at edge E0; word k has out_valid rising at E(1+2k) and its handshake at E(2+2k).
  - done is high during the cycle after E(2*NUM_REGS); busy falls at E(2*NUM_REGS+1).
  - A full dump of 8 registers takes 17 cycles.
- Data is a snapshot per register at its SETUP cycle. Register writes during a dump are reflected only for registers not yet read.
- No arithmetic beyond the idx increment. idx never wraps, because the DONE transition occurs first.

Test Plan:
- Reset, then preload R0..R7 = 16'h1000+k, start pulse, out_ready=1 -> 8 words, index 0..7, data 1000..1007; out_valid at E1,E3,..,E15; done pulse after E16; busy low after E17.
- Same preload, out_ready toggled 1-of-3 cycles -> identical word sequence; out_data/out_index stable while out_valid&!out_ready; no word dropped or duplicated.
- abort asserted in SEND of index 3 with out_ready=1 in the same cycle -> IDLE next edge, out_valid=0, no done, index 3 not counted; a new start re-dumps from index 0.
- Reset asserted mid-dump (index 5, SEND) -> outputs immediately 0 / IDLE without waiting for a clock edge; a later start produces a full 0..7 dump.
- start pulsed again while busy at index 2 -> ignored; exactly 8 words and one done pulse.
- R4 written from 16'hAAAA to 16'h5555 while index 1 is in SEND -> index 4 reports 16'h5555; R0 reports its pre-dump value.
